pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage mips core (pc, if_id, id, id_ex, ex, ex_mem, mem, mem_wb).

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_perf.sv | 25 ++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
// Stall bus bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb.
package pipe_ctrl_pkg;

  localparam int StallW = 6;

  typedef logic [StallW-1:0] StallBus;

  localparam StallBus StallNone = 6'b000000;
  localparam StallBus StallId   = 6'b000111;
  localparam StallBus StallEx   = 6'b001111;
  localparam StallBus StallAll  = 6'b111111;

  typedef enum logic [1:0] {
    CtrlIdle   = 2'd0,
    CtrlExWait = 2'd1,
    CtrlFlush  = 2'd2
  } ctrl_state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters for stall and flush cycles.
// Only instantiated by pipe_ctrl when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  // Count cycles where the pc is held and cycles where a flush is driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (stall_pc) perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (flush)    perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests, times ex
// multi-cycle ops, and sequences flush/redirect for the 5-stage core.
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int STALL_W = StallW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic [CNT_W-1:0]   ex_cycles,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               ex_busy,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
);

  ctrl_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      new_pc_nx;

  // State, remaining-cycle counter and redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CtrlIdle;
      cnt    <= '0;
      new_pc <= 32'h0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      new_pc <= new_pc_nx;
    end
  end

  // Next-state and stall decode; flush beats ex stalls beats id stalls.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    new_pc_nx = new_pc;
    stall     = StallNone;
    unique case (state)
      CtrlIdle: begin
        if (flush_req) begin
          stall     = StallAll;
          new_pc_nx = flush_pc;
          state_nx  = CtrlFlush;
        end else if (stallreq_ex && (ex_cycles != '0)) begin
          stall  = StallEx;
          cnt_nx = ex_cycles - CNT_W'(1);
          if (ex_cycles != CNT_W'(1)) state_nx = CtrlExWait;
        end else if (stallreq_id) begin
          stall = StallId;
        end
      end
      CtrlExWait: begin
        if (flush_req) begin
          stall     = StallAll;
          cnt_nx    = '0;
          new_pc_nx = flush_pc;
          state_nx  = CtrlFlush;
        end else begin
          stall  = StallEx;
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = CtrlIdle;
        end
      end
      CtrlFlush: begin
        if (flush_req) begin
          new_pc_nx = flush_pc;
          state_nx  = CtrlFlush;
        end else begin
          state_nx = CtrlIdle;
        end
      end
      default: state_nx = CtrlIdle;
    endcase
    if (rst) stall = StallNone;
  end

  assign flush   = (state == CtrlFlush);
  assign ex_busy = (state == CtrlExWait);

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_pc       (stall[0]),
    .flush          (flush),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after it.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic [3:0]  ex_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_busy;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int checks = 0;
  int passes = 0;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .ex_cycles      (ex_cycles),
    .flush_req      (flush_req),
    .flush_pc       (flush_pc),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .ex_busy        (ex_busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Advance to 1ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    ex_cycles   = 4'd0;
    flush_req   = 1'b0;
    flush_pc    = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    stallreq_id = 1'b1;
    tick();
    #1;
    checks++;
    if (stall !== 6'b000000) $display("[TB] FAIL reset_stall: got %b want %b", stall, 6'b000000);
    else passes++;
    tick();
    rst = 1'b0;
    stallreq_id = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || ex_busy !== 1'b0 || new_pc !== 32'h0)
      $display("[TB] FAIL reset_state: got flush=%b busy=%b pc=%h want 0 0 0", flush, ex_busy, new_pc);
    else passes++;
    checks++;
    if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0)
      $display("[TB] FAIL reset_perf: got %0d %0d want 0 0", perf_stall_cnt, perf_flush_cnt);
    else passes++;
  endtask

  task automatic test_id_stall();
    do_reset();
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111 || ex_busy !== 1'b0 || flush !== 1'b0)
      $display("[TB] FAIL id_stall: got stall=%b busy=%b flush=%b want 000111 0 0", stall, ex_busy, flush);
    else passes++;
    tick();
    stallreq_id = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000000) $display("[TB] FAIL id_release: got %b want %b", stall, 6'b000000);
    else passes++;
  endtask

  task automatic test_ex_multi();
    do_reset();
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (stall !== 6'b001111 || ex_busy !== (i > 0))
        $display("[TB] FAIL ex4_cycle%0d: got stall=%b busy=%b want 001111 %b", i + 1, stall, ex_busy, i > 0);
      else passes++;
      tick();
      stallreq_ex = 1'b0;
      ex_cycles   = 4'd0;
    end
    #1;
    checks++;
    if (stall !== 6'b000000 || ex_busy !== 1'b0)
      $display("[TB] FAIL ex4_done: got stall=%b busy=%b want 000000 0", stall, ex_busy);
    else passes++;
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    if (perf_stall_cnt !== 32'd4) $display("[TB] FAIL perf_stall: got %0d want 4", perf_stall_cnt);
    else passes++;
`else
    if (perf_stall_cnt !== 32'd0) $display("[TB] FAIL perf_stall: got %0d want 0", perf_stall_cnt);
    else passes++;
`endif
  endtask

  task automatic test_ex_short();
    do_reset();
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd1;
    #1;
    checks++;
    if (stall !== 6'b001111 || ex_busy !== 1'b0)
      $display("[TB] FAIL ex1_stall: got stall=%b busy=%b want 001111 0", stall, ex_busy);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (stall !== 6'b000000 || ex_busy !== 1'b0)
      $display("[TB] FAIL ex1_after: got stall=%b busy=%b want 000000 0", stall, ex_busy);
    else passes++;
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd0;
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111) $display("[TB] FAIL ex0_falls_to_id: got %b want %b", stall, 6'b000111);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ex_busy !== 1'b0 || stall !== 6'b000000)
      $display("[TB] FAIL ex0_no_wait: got busy=%b stall=%b want 0 000000", ex_busy, stall);
    else passes++;
  endtask

  task automatic test_flush_abort();
    do_reset();
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd5;
    tick();
    clear_inputs();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0040;
    #1;
    checks++;
    if (stall !== 6'b111111 || ex_busy !== 1'b1)
      $display("[TB] FAIL abort_stall: got stall=%b busy=%b want 111111 1", stall, ex_busy);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h40 || stall !== 6'b000000 || ex_busy !== 1'b0)
      $display("[TB] FAIL abort_flush: got flush=%b pc=%h stall=%b busy=%b want 1 00000040 000000 0",
               flush, new_pc, stall, ex_busy);
    else passes++;
    tick();
    #1;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b000000 || new_pc !== 32'h40)
      $display("[TB] FAIL abort_idle: got flush=%b stall=%b pc=%h want 0 000000 00000040", flush, stall, new_pc);
    else passes++;
    checks++;
`ifdef PIPE_CTRL_PERF_EN
    if (perf_flush_cnt !== 32'd1 || perf_stall_cnt !== 32'd2)
      $display("[TB] FAIL perf_abort: got %0d %0d want 2 1", perf_stall_cnt, perf_flush_cnt);
    else passes++;
`else
    if (perf_flush_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("[TB] FAIL perf_abort: got %0d %0d want 0 0", perf_stall_cnt, perf_flush_cnt);
    else passes++;
`endif
  endtask

  task automatic test_priority();
    do_reset();
    flush_req   = 1'b1;
    flush_pc    = 32'h0000_0100;
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd3;
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b111111) $display("[TB] FAIL prio_stall: got %b want %b", stall, 6'b111111);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (flush !== 1'b1 || ex_busy !== 1'b0 || new_pc !== 32'h100)
      $display("[TB] FAIL prio_flush: got flush=%b busy=%b pc=%h want 1 0 00000100", flush, ex_busy, new_pc);
    else passes++;
    tick();
    #1;
    checks++;
    if (ex_busy !== 1'b0 || stall !== 6'b000000 || flush !== 1'b0)
      $display("[TB] FAIL prio_no_ex: got busy=%b stall=%b flush=%b want 0 000000 0", ex_busy, stall, flush);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0040;
    tick();
    flush_pc    = 32'h0000_0080;
    stallreq_id = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b000000)
      $display("[TB] FAIL b2b_first: got flush=%b stall=%b want 1 000000", flush, stall);
    else passes++;
    tick();
    clear_inputs();
    #1;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h80)
      $display("[TB] FAIL b2b_second: got flush=%b pc=%h want 1 00000080", flush, new_pc);
    else passes++;
    tick();
    #1;
    checks++;
    if (flush !== 1'b0) $display("[TB] FAIL b2b_end: got %b want 0", flush);
    else passes++;
  endtask

  task automatic test_reset_midway();
    do_reset();
    stallreq_ex = 1'b1;
    ex_cycles   = 4'd4;
    tick();
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000000 || ex_busy !== 1'b1)
      $display("[TB] FAIL rst_wait_during: got stall=%b busy=%b want 000000 1", stall, ex_busy);
    else passes++;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b0 || ex_busy !== 1'b0 || perf_stall_cnt !== 32'h0)
      $display("[TB] FAIL rst_wait_after: got stall=%b flush=%b busy=%b perf=%0d want 000000 0 0 0",
               stall, flush, ex_busy, perf_stall_cnt);
    else passes++;
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0200;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || stall !== 6'b000000)
      $display("[TB] FAIL rst_flush_after: got flush=%b pc=%h stall=%b want 0 00000000 000000",
               flush, new_pc, stall);
    else passes++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_id_stall();
    test_ex_multi();
    test_ex_short();
    test_flush_abort();
    test_priority();
    test_back_to_back();
    test_reset_midway();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
